ascii_packer: RTL and testbench

ASCII_PACKER -- requirements
Module: ascii_packer

---
 rtl/ascii_packer.sv | 77 +++++++
 tb/tb_ascii_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ascii_packer.sv
// ascii_packer: packs 7-bit ASCII characters into 5-bit codes, CPW codes per output word.
// Define DROP_UNMAPPED_EN to drop unmapped characters instead of storing them as code 0.
module ascii_packer #(
  parameter int CPW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [6:0]       in_ascii,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5*CPW-1:0] out_word,
  output logic [2:0]       out_count,
  output logic [7:0]       err_cnt
);
  typedef enum logic {FILL, EMIT} state_t;
`ifdef DROP_UNMAPPED_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [5*CPW-1:0] word_q, word_d;
  logic [7:0] err_q, err_d;
  logic lower, mapped, store, accept;
  logic [4:0] code;
  assign lower = in_ascii >= 7'h61 && in_ascii <= 7'h7A;
  assign mapped = lower || in_ascii == 7'h20 || in_ascii == 7'h2C || in_ascii == 7'h2E || in_ascii == 7'h3F;
  assign code = lower ? 5'(in_ascii - 7'h60) :
                in_ascii == 7'h2C ? 5'd29 :
                in_ascii == 7'h2E ? 5'd30 :
                in_ascii == 7'h3F ? 5'd31 : 5'd0;
  assign accept = in_valid && state_q == FILL;
  assign store = mapped || !DROP;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    word_d = word_q;
    err_d = err_q;
    if (accept) begin
      err_d = (!mapped && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
      if (store) begin
        for (int k = 0; k < CPW; k++)
          if (idx_q == 3'(k)) word_d[5*k +: 5] = code;
        idx_d = idx_q + 3'd1;
      end
      // a dropped last character still closes the message, but only if something is buffered
      if (store ? (idx_q == 3'(CPW-1) || in_last) : (in_last && idx_q != 3'd0)) state_d = EMIT;
    end
    if (state_q == EMIT && out_ready) begin
      state_d = FILL;
      idx_d = '0;
      word_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q <= '0;
      word_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      word_q <= word_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == FILL;
  assign out_valid = state_q == EMIT;
  assign out_word = word_q;
  assign out_count = idx_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_ascii_packer.sv
// tb_ascii_packer: randomized + directed scoreboard bench for ascii_packer against a message-level model.
module tb_ascii_packer;
  localparam int CPW = 3;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [6:0] in_ascii = '0;
  logic in_ready, out_valid;
  logic [5*CPW-1:0] out_word;
  logic [2:0] out_count;
  logic [7:0] err_cnt;
  int checks = 0, failures = 0;
  bit auto_rdy = 0, rand_rdy = 0;
  int buf_q[$];
  logic [5*CPW-1:0] exp_w[$];
  logic [2:0] exp_c[$];
  int err_m = 0;

  ascii_packer #(.CPW(CPW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ascii(in_ascii), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_count(out_count), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (auto_rdy) out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;

  function automatic int map_code(input logic [6:0] ch);
    if (ch == 7'h20) return 0;
    if (ch >= "a" && ch <= "z") return int'(ch) - int'("a") + 1;
    if (ch == ",") return 29;
    if (ch == ".") return 30;
    if (ch == "?") return 31;
    return -1;
  endfunction

  task automatic flush_word();
    logic [5*CPW-1:0] w = '0;
    foreach (buf_q[k]) w = w | ((5*CPW)'(buf_q[k]) << (5*k));
    exp_w.push_back(w);
    exp_c.push_back(3'(buf_q.size()));
    buf_q.delete();
  endtask

  task automatic model_accept(input logic [6:0] ch, input bit last);
    int c = map_code(ch);
    bit drop = 0;
`ifdef DROP_UNMAPPED_EN
    drop = 1;
`endif
    if (c < 0 && err_m < 255) err_m++;
    if (c < 0 && drop) begin
      if (last && buf_q.size() > 0) flush_word();
    end else begin
      buf_q.push_back(c < 0 ? 0 : c);
      if (buf_q.size() == CPW || last) flush_word();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [6:0] ch, input bit last);
    bit rdy;
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_ascii = ch; in_last = last;
    do begin
      rdy = in_ready;
      @(posedge clk);
      n++;
      if (!rdy) @(negedge clk);
    end while (!rdy && n < 300);
    #1 in_valid = 0; in_last = 0;
    if (rdy) model_accept(ch, last);
    else begin
      checks++; failures++;
      $display("FAIL send_timeout got=in_ready_low expected=accept char=%h", ch);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_w.size() > 0 && n < 1000) begin @(posedge clk); n++; end
    @(negedge clk); @(negedge clk);
    chk("drain_pending", exp_w.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    buf_q.delete(); exp_w.delete(); exp_c.delete(); err_m = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_out_word", out_word, 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin : monitor
    logic [5*CPW-1:0] ew;
    logic [2:0] ec;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (exp_w.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got=%h count=%0d expected=none", out_word, out_count);
        end else begin
          ew = exp_w.pop_front();
          ec = exp_c.pop_front();
          if (out_word !== ew || out_count !== ec) begin
            failures++;
            $display("FAIL word got=%h/%0d expected=%h/%0d", out_word, out_count, ew, ec);
          end
        end
      end
    end
  end

  initial begin
    logic [6:0] ch;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_word", out_word, 0);
    chk("reset_out_count", out_count, 0);
    chk("reset_err_cnt", err_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    #1 chk("reset_in_ready", in_ready, 1);
    auto_rdy = 1; out_ready = 1;

    send("a", 0); send("b", 0); send("c", 1);
    chk("abc_valid_latency", out_valid, 1);
    chk("abc_word", out_word, 15'h0C41);
    chk("abc_count", out_count, 3);
    drain();

    send("z", 0); send("?", 1);
    chk("zq_word", out_word, 15'h03FA);
    chk("zq_count", out_count, 2);
    drain();

    auto_rdy = 0; out_ready = 0;
    send("a", 0); send("b", 0); send("c", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("hold_word", out_word, 15'h0C41);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    chk("release_in_ready", in_ready, 1);
    auto_rdy = 1;
    drain();

    send("h", 0); send(7'h41, 0); send("i", 1);
`ifdef DROP_UNMAPPED_EN
    chk("hai_word", out_word, 15'h0128);
    chk("hai_count", out_count, 2);
`else
    chk("hai_word", out_word, 15'h2408);
    chk("hai_count", out_count, 3);
`endif
    drain();
    chk("hai_err_cnt", err_cnt, 1);

    send("x", 0); send("y", 0);
    pulse_reset();
    send("a", 0); send("b", 0); send("c", 1);
    drain();
    chk("post_reset_err", err_cnt, 0);

    rand_rdy = 1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 9))
        0: ch = 7'h20;
        1, 2, 3, 4, 5, 6: ch = 7'(int'("a") + $urandom_range(0, 25));
        7: ch = ($urandom_range(0, 2) == 0) ? 7'h2C : ($urandom_range(0, 1) == 0) ? 7'h2E : 7'h3F;
        default: ch = 7'($urandom_range(0, 127));
      endcase
      send(ch, $urandom_range(0, 5) == 0);
    end
    drain();
    chk("random_err_cnt", err_cnt, err_m);

    pulse_reset();
    for (int i = 0; i < 300; i++) send(7'(7'h41 + $urandom_range(0, 25)), (i % 7) == 6);
    drain();
    chk("sat_err_cnt", err_cnt, 255);
    for (int i = 0; i < 5; i++) send(7'h5B, 0);
    send(7'h7F, 1);
    drain();
    chk("sat_err_hold", err_cnt, 255);
    chk("sat_model", err_m, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
